// File: rtl/simon128_iter_core.sv
// simon128_iter_core
// Iterative Simon 128/128 encryption engine: 64-bit words, two key words,
// 68 rounds, z2 constant sequence, key schedule expanded on the fly.
// UNROLL rounds are evaluated per clock (1, 2 or 4), giving 68/UNROLL run cycles.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start_i  in   start request, accepted only while idle or done
//   pt_i     in   plaintext {x, y}, sampled on the accept edge only
//   k0_i     in   key {k1, k0}, sampled on the accept edge only
//   busy_o   out  high while rounds are being computed
//   valid_o  out  sticky completion flag, cleared by the next accepted start
//   ct_o     out  ciphertext {x, y}, held until the next completion
module simon128_iter_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] pt_i,
  input  logic [127:0] k0_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [127:0] ct_o
);

  // UNROLL must divide 68; the last run edge is the one whose rounds end at 68.
  localparam int         NR       = 68 / UNROLL;
  localparam logic [6:0] RND_STEP = 7'(UNROLL);
  localparam logic [6:0] RND_LAST = 7'((NR - 1) * UNROLL);

  // z2 with bit index 0 at the leftmost position, so bit i lives at Z2[61-i].
  localparam logic [61:0] Z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [63:0]  x_q, y_q, ka_q, kb_q;
  logic [6:0]   rnd_q;
  logic [5:0]   zIdx_q;
  logic [127:0] ct_q;
  logic         valid_q;

  logic         accept;
  logic         lastEdge;

  logic [63:0]  x_d, y_d, ka_d, kb_d;
  logic [63:0]  xTmp, kTmp;
  logic [6:0]   zPos;
  logic [6:0]   zSum;
  logic [5:0]   zIdx_d;

  // f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x)
  function automatic logic [63:0] roundF(input logic [63:0] v);
    return ({v[62:0], v[63]} & {v[55:0], v[63:56]}) ^ {v[61:0], v[63:62]};
  endfunction

  // Next key word from the two most recent ones and the current z2 bit.
  function automatic logic [63:0] keyStep(input logic [63:0] ka,
                                          input logic [63:0] kb,
                                          input logic        zBit);
    logic [63:0] t;
    t = {kb[2:0], kb[63:3]};
    t = t ^ {t[0], t[63:1]};
    return ~ka ^ t ^ 64'h3 ^ {63'b0, zBit};
  endfunction

  assign accept   = start_i && (state_q != RUN);
  assign lastEdge = (state_q == RUN) && (rnd_q == RND_LAST);

  // Chain UNROLL rounds in place. Each lane takes the z2 bit for its own round,
  // wrapping the sequence position past 61 back to 0.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    ka_d = ka_q;
    kb_d = kb_q;
    xTmp = '0;
    kTmp = '0;
    zPos = '0;
    for (int j = 0; j < UNROLL; j++) begin
      zPos = {1'b0, zIdx_q} + 7'(j);
      if (zPos >= 7'd62) begin
        zPos = zPos - 7'd62;
      end
      xTmp = y_d ^ roundF(x_d) ^ ka_d;
      kTmp = keyStep(ka_d, kb_d, Z2[6'd61 - zPos[5:0]]);
      y_d  = x_d;
      x_d  = xTmp;
      ka_d = kb_d;
      kb_d = kTmp;
    end
  end

  // z2 position after this edge's rounds, wrapped into 0..61.
  always_comb begin
    zSum = {1'b0, zIdx_q} + RND_STEP;
    if (zSum >= 7'd62) begin
      zSum = zSum - 7'd62;
    end
    zIdx_d = zSum[5:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (lastEdge) state_d = DONE;
      DONE:    if (start_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: load on accept, advance while running, capture the result on the
  // final run edge. Once rnd reaches 68 the engine leaves RUN, so it never grows
  // beyond that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      rnd_q   <= '0;
      zIdx_q  <= '0;
      ct_q    <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      x_q     <= pt_i[127:64];
      y_q     <= pt_i[63:0];
      ka_q    <= k0_i[63:0];
      kb_q    <= k0_i[127:64];
      rnd_q   <= '0;
      zIdx_q  <= '0;
      valid_q <= 1'b0;
    end else if (state_q == RUN) begin
      x_q    <= x_d;
      y_q    <= y_d;
      ka_q   <= ka_d;
      kb_q   <= kb_d;
      rnd_q  <= rnd_q + RND_STEP;
      zIdx_q <= zIdx_d;
      if (lastEdge) begin
        ct_q    <= {x_d, y_d};
        valid_q <= 1'b1;
      end
    end
  end

  assign busy_o  = (state_q == RUN);
  assign valid_o = valid_q;
  assign ct_o    = ct_q;

endmodule

// File: tb/tb_simon128_iter_core.sv
// tb_simon128_iter_core
// Drives three engines (UNROLL = 1, 2, 4) from shared inputs and checks
// latency, known-answer ciphertext, ignored restarts, reset abort,
// back-to-back random blocks against a reference model, and continuous start.
module tb_simon128_iter_core;

  localparam logic [127:0] KAT_PT  = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KAT_CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] pt_i;
  logic [127:0] k0_i;
  logic         busy1, valid1, busy2, valid2, busy4, valid4;
  logic [127:0] ct1, ct2, ct4;

  int checkCnt = 0;
  int passCnt  = 0;

  typedef struct {
    int   n;
    logic busy1;
    logic valid1;
    logic valid2;
    logic valid4;
  } latRow_t;

  latRow_t latTab[10];

  always #5 clk = ~clk;

  simon128_iter_core #(.UNROLL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .pt_i(pt_i), .k0_i(k0_i),
    .busy_o(busy1), .valid_o(valid1), .ct_o(ct1)
  );

  simon128_iter_core #(.UNROLL(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .pt_i(pt_i), .k0_i(k0_i),
    .busy_o(busy2), .valid_o(valid2), .ct_o(ct2)
  );

  simon128_iter_core #(.UNROLL(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .pt_i(pt_i), .k0_i(k0_i),
    .busy_o(busy4), .valid_o(valid4), .ct_o(ct4)
  );

  function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int s);
    return (v << s) | (v >> (64 - s));
  endfunction

  // Textbook Simon 128/128: expand all 68 round keys first, then run the rounds.
  function automatic logic [127:0] simonRef(input logic [127:0] pt,
                                            input logic [127:0] key);
    logic [63:0] k[68];
    logic [61:0] z;
    logic [63:0] x, y, tmp, zBit;
    z = 62'b10101111011100000011010010011000101000010001111110010110110011;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      zBit = 64'((z >> (61 - (i % 62))) & 62'd1);
      k[i+2] = 64'hffff_ffff_ffff_fffc ^ zBit ^ k[i]
               ^ ror64(k[i+1], 3) ^ ror64(k[i+1], 4);
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      tmp = x;
      x = y ^ (rol64(x, 1) & rol64(x, 8)) ^ rol64(x, 2) ^ k[i];
      y = tmp;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] randVec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive inputs, then advance through one rising edge to the next falling edge.
  task automatic applyStimulus(input logic s, input logic [127:0] p,
                               input logic [127:0] k);
    start_i = s;
    pt_i    = p;
    k0_i    = k;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checkCnt++;
    if (act === exp) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [127:0] prevExp, expCt;
    logic [127:0] p, k;
    logic [127:0] vp[3];
    logic [127:0] vk[3];
    logic [127:0] ve[3];
    logic         sawValid;
    int           blk;

    latTab[0] = '{n: 0,  busy1: 1'b1, valid1: 1'b0, valid2: 1'b0, valid4: 1'b0};
    latTab[1] = '{n: 1,  busy1: 1'b1, valid1: 1'b0, valid2: 1'b0, valid4: 1'b0};
    latTab[2] = '{n: 16, busy1: 1'b1, valid1: 1'b0, valid2: 1'b0, valid4: 1'b0};
    latTab[3] = '{n: 17, busy1: 1'b1, valid1: 1'b0, valid2: 1'b0, valid4: 1'b1};
    latTab[4] = '{n: 33, busy1: 1'b1, valid1: 1'b0, valid2: 1'b0, valid4: 1'b1};
    latTab[5] = '{n: 34, busy1: 1'b1, valid1: 1'b0, valid2: 1'b1, valid4: 1'b1};
    latTab[6] = '{n: 67, busy1: 1'b1, valid1: 1'b0, valid2: 1'b1, valid4: 1'b1};
    latTab[7] = '{n: 68, busy1: 1'b0, valid1: 1'b1, valid2: 1'b1, valid4: 1'b1};
    latTab[8] = '{n: 69, busy1: 1'b0, valid1: 1'b1, valid2: 1'b1, valid4: 1'b1};
    latTab[9] = '{n: 70, busy1: 1'b0, valid1: 1'b1, valid2: 1'b1, valid4: 1'b1};

    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0);
    applyStimulus(1'b1, KAT_PT, KAT_KEY);
    checkOutput("reset ct1", ct1, '0);
    checkOutput("reset valid1", 128'(valid1), 128'(0));
    checkOutput("reset busy1", 128'(busy1), 128'(0));
    checkOutput("reset busy4", 128'(busy4), 128'(0));
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0);
    checkOutput("idle busy1", 128'(busy1), 128'(0));

    // Known answer on all three unroll factors, latency from the table
    applyStimulus(1'b1, KAT_PT, KAT_KEY);
    for (int n = 0; n <= 70; n++) begin
      if (n > 0) applyStimulus(1'b0, randVec(), randVec());
      foreach (latTab[r]) begin
        if (latTab[r].n == n) begin
          checkOutput($sformatf("kat busy1 n=%0d", n), 128'(busy1), 128'(latTab[r].busy1));
          checkOutput($sformatf("kat valid1 n=%0d", n), 128'(valid1), 128'(latTab[r].valid1));
          checkOutput($sformatf("kat valid2 n=%0d", n), 128'(valid2), 128'(latTab[r].valid2));
          checkOutput($sformatf("kat valid4 n=%0d", n), 128'(valid4), 128'(latTab[r].valid4));
        end
      end
    end
    checkOutput("kat ct1", ct1, KAT_CT);
    checkOutput("kat ct2", ct2, KAT_CT);
    checkOutput("kat ct4", ct4, KAT_CT);

    // Start during RUN with inputs changing every cycle
    applyStimulus(1'b1, KAT_PT, KAT_KEY);
    checkOutput("restart valid1 drop", 128'(valid1), 128'(0));
    for (int n = 1; n <= 68; n++) begin
      applyStimulus(n == 10, randVec(), randVec());
      if (n == 67) checkOutput("midstart valid1 n=67", 128'(valid1), 128'(0));
    end
    checkOutput("midstart valid1 n=68", 128'(valid1), 128'(1));
    checkOutput("midstart ct1", ct1, KAT_CT);
    checkOutput("midstart ct2", ct2, KAT_CT);
    checkOutput("midstart ct4", ct4, KAT_CT);

    // Reset mid-operation
    applyStimulus(1'b1, KAT_PT, KAT_KEY);
    for (int n = 1; n < 30; n++) applyStimulus(1'b0, randVec(), randVec());
    rst_n = 1'b0;
    #1;
    checkOutput("rst ct1", ct1, '0);
    checkOutput("rst busy1", 128'(busy1), 128'(0));
    checkOutput("rst valid4", 128'(valid4), 128'(0));
    applyStimulus(1'b0, '0, '0);
    applyStimulus(1'b0, '0, '0);
    checkOutput("rst hold valid1", 128'(valid1), 128'(0));
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int n = 0; n < 80; n++) begin
      applyStimulus(1'b0, randVec(), randVec());
      sawValid = sawValid | valid1 | valid2 | valid4 | busy1;
    end
    checkOutput("post-rst spurious", 128'(sawValid), 128'(0));
    applyStimulus(1'b1, KAT_PT, KAT_KEY);
    checkOutput("rerun busy1", 128'(busy1), 128'(1));
    for (int n = 1; n <= 68; n++) begin
      applyStimulus(1'b0, randVec(), randVec());
      if (n == 67) checkOutput("rerun valid1 n=67", 128'(valid1), 128'(0));
    end
    checkOutput("rerun valid1 n=68", 128'(valid1), 128'(1));
    checkOutput("rerun ct1", ct1, KAT_CT);

    // Back-to-back random blocks against the reference model
    prevExp = KAT_CT;
    for (int b = 0; b < 200; b++) begin
      p = randVec();
      k = randVec();
      expCt = simonRef(p, k);
      applyStimulus(1'b1, p, k);
      checkOutput($sformatf("b2b%0d accept valid1", b), 128'(valid1), 128'(0));
      checkOutput($sformatf("b2b%0d hold ct1", b), ct1, prevExp);
      for (int n = 1; n <= 68; n++) begin
        applyStimulus(1'b0, randVec(), randVec());
        if (n == 40) checkOutput($sformatf("b2b%0d mid ct1", b), ct1, prevExp);
      end
      checkOutput($sformatf("b2b%0d valid1", b), 128'(valid1), 128'(1));
      checkOutput($sformatf("b2b%0d ct1", b), ct1, expCt);
      checkOutput($sformatf("b2b%0d ct2", b), ct2, expCt);
      checkOutput($sformatf("b2b%0d ct4", b), ct4, expCt);
      prevExp = expCt;
    end

    // start_i held high: three blocks back to back
    vp[0] = KAT_PT;
    vk[0] = KAT_KEY;
    for (int i = 1; i < 3; i++) begin
      vp[i] = randVec();
      vk[i] = randVec();
    end
    for (int i = 0; i < 3; i++) ve[i] = simonRef(vp[i], vk[i]);
    applyStimulus(1'b1, vp[0], vk[0]);
    for (int n = 1; n <= 206; n++) begin
      blk = (n <= 69) ? 1 : 2;
      applyStimulus(1'b1, vp[blk], vk[blk]);
      if (n == 67) checkOutput("cont valid1 n=67", 128'(valid1), 128'(0));
      if (n == 68 || n == 137 || n == 206) begin
        blk = (n == 68) ? 0 : ((n == 137) ? 1 : 2);
        checkOutput($sformatf("cont valid1 n=%0d", n), 128'(valid1), 128'(1));
        checkOutput($sformatf("cont ct1 n=%0d", n), ct1, ve[blk]);
      end
      if (n == 69 || n == 138) begin
        blk = (n == 69) ? 0 : 1;
        checkOutput($sformatf("cont drop valid1 n=%0d", n), 128'(valid1), 128'(0));
        checkOutput($sformatf("cont hold ct1 n=%0d", n), ct1, ve[blk]);
      end
    end
    applyStimulus(1'b0, '0, '0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
